// File: rtl/counter_sec_if.sv
// ============================================================================
// counter_sec_if : control and status bundle of the seconds stage
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface counter_sec_if;
  logic       run;
  logic       clr_sec;
  logic       adj_min_n;
  logic [5:0] rst_numb_sec;
  logic       tick_1Hz;
  logic [5:0] out_sec;
  logic       inc_min;

  modport master (
    output run, clr_sec, adj_min_n, rst_numb_sec,
    input  tick_1Hz, out_sec, inc_min
  );

  modport slave (
    input  run, clr_sec, adj_min_n, rst_numb_sec,
    output tick_1Hz, out_sec, inc_min
  );
endinterface

`default_nettype wire

// File: rtl/counter_sec.sv
// ============================================================================
// counter_sec : 1 Hz prescaler, seconds counter and inc_min pulse generator.
// Optional button debouncer enabled by defining ADJ_DEBOUNCE_EN.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module counter_sec #(
  parameter int CLK_FREQ   = 50_000_000,
  parameter int PULSE_W    = 4,
  parameter int DEB_CYCLES = 1_000_000
) (
  input  logic          clk_50MHz,
  input  logic          rst_n,
  counter_sec_if.slave  bus
);

  localparam int PRESC_W = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
  localparam logic [PRESC_W-1:0] PRESC_TC  = PRESC_W'(CLK_FREQ - 1);
  localparam logic [PRESC_W-1:0] PRESC_PRE = PRESC_W'(CLK_FREQ - 2);
  localparam int PCNT_W = (PULSE_W > 2) ? $clog2(PULSE_W) : 1;
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_W - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_t;

  logic [PRESC_W-1:0] presc_q, presc_d;
  logic               tick_q, tick_d;
  logic [5:0]         sec_q, sec_d;
  logic               sec_req_q, sec_req_d;
  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               btn_prev_q, btn_prev_d;
  logic               adj_req_q, adj_req_d;
  logic [1:0]         pend_q, pend_d;
  state_t             state_q, state_d;
  logic [PCNT_W-1:0]  pcnt_q, pcnt_d;
  logic               inc_q, inc_d;
  logic               btn_lvl;
  logic               start_pulse;
  logic [2:0]         pend_sum;

  // Tick is registered one cycle ahead so it is high while the prescaler sits at terminal count.
  always_comb begin
    presc_d   = presc_q;
    tick_d    = 1'b0;
    sec_d     = sec_q;
    sec_req_d = 1'b0;
    if (bus.clr_sec) begin
      presc_d = '0;
      sec_d   = '0;
    end else begin
      if (bus.run) begin
        presc_d = (presc_q == PRESC_TC) ? '0 : presc_q + 1'b1;
        tick_d  = (presc_q == PRESC_PRE);
      end
      if (tick_q) begin
        if (sec_q >= bus.rst_numb_sec) begin
          sec_d     = '0;
          sec_req_d = 1'b1;
        end else begin
          sec_d = sec_q + 6'd1;
        end
      end
    end
  end

`ifdef ADJ_DEBOUNCE_EN
  localparam int DEB_W = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 1);

  logic             deb_q, deb_d;
  logic [DEB_W-1:0] deb_cnt_q, deb_cnt_d;

  always_comb begin
    deb_d     = deb_q;
    deb_cnt_d = '0;
    if (sync2_q != deb_q) begin
      if (deb_cnt_q == DEB_LAST) begin
        deb_d = sync2_q;
      end else begin
        deb_cnt_d = deb_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      deb_q     <= 1'b1;
      deb_cnt_q <= '0;
    end else begin
      deb_q     <= deb_d;
      deb_cnt_q <= deb_cnt_d;
    end
  end

  assign btn_lvl = deb_q;
`else
  assign btn_lvl = sync2_q;
`endif

  always_comb begin
    sync1_d    = bus.adj_min_n;
    sync2_d    = sync1_q;
    btn_prev_d = btn_lvl;
    adj_req_d  = btn_prev_q & ~btn_lvl;
  end

  always_comb begin
    state_d     = state_q;
    pcnt_d      = pcnt_q;
    start_pulse = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((pend_q != 2'd0) || sec_req_q || adj_req_q) begin
          state_d     = S_HIGH;
          pcnt_d      = '0;
          start_pulse = 1'b1;
        end
      end
      S_HIGH: begin
        if (pcnt_q == PCNT_LAST) begin
          state_d = S_LOW;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      S_LOW: begin
        if (pcnt_q == PCNT_LAST) begin
          state_d = S_IDLE;
          pcnt_d  = '0;
        end else begin
          pcnt_d = pcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        pcnt_d  = '0;
      end
    endcase
    inc_d = (state_d == S_HIGH);
  end

  // A leave from IDLE always has at least one request behind it, so the subtract cannot underflow.
  always_comb begin
    pend_sum = {1'b0, pend_q} + {2'b00, sec_req_q} + {2'b00, adj_req_q}
             - {2'b00, start_pulse};
    pend_d   = (pend_sum > 3'd3) ? 2'd3 : pend_sum[1:0];
  end

  always_ff @(posedge clk_50MHz or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      tick_q     <= 1'b0;
      sec_q      <= '0;
      sec_req_q  <= 1'b0;
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      btn_prev_q <= 1'b1;
      adj_req_q  <= 1'b0;
      pend_q     <= 2'd0;
      state_q    <= S_IDLE;
      pcnt_q     <= '0;
      inc_q      <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      tick_q     <= tick_d;
      sec_q      <= sec_d;
      sec_req_q  <= sec_req_d;
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      btn_prev_q <= btn_prev_d;
      adj_req_q  <= adj_req_d;
      pend_q     <= pend_d;
      state_q    <= state_d;
      pcnt_q     <= pcnt_d;
      inc_q      <= inc_d;
    end
  end

  assign bus.tick_1Hz = tick_q;
  assign bus.out_sec  = sec_q;
  assign bus.inc_min  = inc_q;

endmodule

`default_nettype wire

// File: tb/tb_counter_sec.sv
// ============================================================================
// tb_counter_sec : self-checking bench for counter_sec (CLK_FREQ=10, PULSE_W=4)
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_counter_sec;

  localparam int CF  = 10;
  localparam int PW  = 4;
  localparam int DEB = 8;
`ifdef ADJ_DEBOUNCE_EN
  localparam bit DEB_BUILD = 1'b1;
`else
  localparam bit DEB_BUILD = 1'b0;
`endif

  logic clk_50MHz = 1'b0;
  logic rst_n     = 1'b1;

  counter_sec_if bus_if ();

  counter_sec #(
    .CLK_FREQ  (CF),
    .PULSE_W   (PW),
    .DEB_CYCLES(DEB)
  ) dut (
    .clk_50MHz(clk_50MHz),
    .rst_n    (rst_n),
    .bus      (bus_if)
  );

  always #5 clk_50MHz = ~clk_50MHz;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_rise, n_high;
  bit inc_prev;
  bit inc_hist [0:127];
  bit model_on = 1'b1;

  // Reference model: pulse occupancy is tracked as a time window, not as states.
  int m_presc, m_sec, m_tick, m_sreq, m_areq, m_pend, m_start, m_free;
  bit [3:0] m_hist;

  typedef struct {
    int lim;
    int ncyc;
    int exp_sec;
    int exp_rise;
  } vec_t;
  vec_t tbl [6];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void model_reset();
    m_presc = 0; m_sec = 0; m_tick = 0; m_sreq = 0; m_areq = 0; m_pend = 0;
    m_start = -1000; m_free = 0; m_hist = 4'b1111; cyc = 0;
  endfunction

  function automatic void model_edge();
    int reqs, tot, lim, sreq_new, tick_new;
    if (!rst_n) begin
      model_reset();
      return;
    end
    reqs = m_sreq + m_areq;
    tot  = m_pend + reqs;
    if (cyc >= m_free && tot > 0) begin
      m_start = cyc + 1;
      m_free  = cyc + 1 + 2 * PW;
      tot--;
    end
    m_pend = (tot > 3) ? 3 : tot;
    m_hist = {m_hist[2:0], bus_if.adj_min_n};
    lim = int'(bus_if.rst_numb_sec);
    sreq_new = 0;
    tick_new = 0;
    if (bus_if.clr_sec) begin
      m_presc = 0;
      m_sec   = 0;
    end else begin
      if (m_tick != 0) begin
        if (m_sec >= lim) begin
          m_sec = 0;
          sreq_new = 1;
        end else begin
          m_sec++;
        end
      end
      if (bus_if.run) begin
        m_presc  = (m_presc + 1) % CF;
        tick_new = (m_presc == CF - 1) ? 1 : 0;
      end
    end
    m_tick = tick_new;
    m_sreq = sreq_new;
    m_areq = (m_hist[3] && !m_hist[2]) ? 1 : 0;
    cyc++;
  endfunction

  task automatic step();
    int exp_inc;
    @(posedge clk_50MHz);
    model_edge();
    #1;
    exp_inc = (cyc >= m_start && cyc < m_start + PW) ? 1 : 0;
    if (model_on) begin
      check("model_tick", int'(bus_if.tick_1Hz), m_tick);
      check("model_sec",  int'(bus_if.out_sec),  m_sec);
      check("model_inc",  int'(bus_if.inc_min),  exp_inc);
    end
    if (bus_if.inc_min && !inc_prev) n_rise++;
    if (bus_if.inc_min) n_high++;
    inc_prev = bus_if.inc_min;
    if (cyc < 128) inc_hist[cyc] = bus_if.inc_min;
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus_if.run = 1'b1;
    bus_if.clr_sec = 1'b0;
    bus_if.adj_min_n = 1'b1;
    bus_if.rst_numb_sec = 6'd59;
    model_reset();
    repeat (2) step();
    check("reset_tick", int'(bus_if.tick_1Hz), 0);
    check("reset_sec",  int'(bus_if.out_sec),  0);
    check("reset_inc",  int'(bus_if.inc_min),  0);
    rst_n = 1'b1;
    model_reset();
    n_rise = 0; n_high = 0; inc_prev = 1'b0;
    for (int i = 0; i < 128; i++) inc_hist[i] = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int n_t, n_bad, seg;

    tbl[0] = '{59, 610,  1, 1};
    tbl[1] = '{59, 598, 59, 0};
    tbl[2] = '{ 0,  55,  0, 5};
    tbl[3] = '{ 3,  85,  0, 2};
    tbl[4] = '{ 9, 100,  0, 0};
    tbl[5] = '{63, 300, 30, 0};

    #1;
    for (int v = 0; v < 6; v++) begin
      do_reset();
      bus_if.rst_numb_sec = 6'(tbl[v].lim);
      run_to(tbl[v].ncyc);
      check($sformatf("tbl%0d_sec", v),  int'(bus_if.out_sec), tbl[v].exp_sec);
      check($sformatf("tbl%0d_rise", v), n_rise, tbl[v].exp_rise);
      check($sformatf("tbl%0d_high", v), n_high, 4 * tbl[v].exp_rise);
    end

    // Lowering the wrap limit below the current seconds value
    do_reset();
    run_to(450);
    check("lower_sec45", int'(bus_if.out_sec), 45);
    bus_if.rst_numb_sec = 6'd30;
    run_to(459);
    check("lower_tick", int'(bus_if.tick_1Hz), 1);
    step();
    check("lower_wrap_sec", int'(bus_if.out_sec), 0);
    step();
    check("lower_inc_high", int'(bus_if.inc_min), 1);
    run_to(480);
    check("lower_rise", n_rise, 1);

    // Hold with run=0, resume, then clear on the tick cycle
    do_reset();
    run_to(35);
    check("hold_sec_before", int'(bus_if.out_sec), 3);
    bus_if.run = 1'b0;
    n_t = 0; n_bad = 0;
    repeat (25) begin
      step();
      if (bus_if.tick_1Hz) n_t++;
      if (bus_if.out_sec != 6'd3) n_bad++;
    end
    check("hold_ticks", n_t, 0);
    check("hold_sec_moves", n_bad, 0);
    bus_if.run = 1'b1;
    run_to(63);
    check("resume_no_tick_yet", int'(bus_if.tick_1Hz), 0);
    step();
    check("resume_tick", int'(bus_if.tick_1Hz), 1);
    step();
    check("resume_sec", int'(bus_if.out_sec), 4);
    run_to(73);
    bus_if.clr_sec = 1'b1;
    step();
    bus_if.clr_sec = 1'b0;
    check("clr_tick_suppressed", int'(bus_if.tick_1Hz), 0);
    check("clr_sec", int'(bus_if.out_sec), 0);
    run_to(83);
    check("clr_next_tick", int'(bus_if.tick_1Hz), 1);
    run_to(90);
    check("clr_no_inc", n_rise, 0);

    model_on = !DEB_BUILD;
`ifndef ADJ_DEBOUNCE_EN
    // Wrap request and adjust request land in the same cycle
    do_reset();
    bus_if.rst_numb_sec = 6'd1;
    while (cyc < 40) begin
      step();
      bus_if.adj_min_n = (cyc == 17) ? 1'b0 : 1'b1;
    end
    check("dual_rise", n_rise, 2);
    check("dual_high", n_high, 8);
    check("dual_first_last_high", int'(inc_hist[24]), 1);
    check("dual_first_low", int'(inc_hist[25]), 0);
    check("dual_idle_gap", int'(inc_hist[29]), 0);
    check("dual_second_high", int'(inc_hist[30]), 1);

    // Asynchronous reset in the HIGH phase with two requests queued
    do_reset();
    bus_if.rst_numb_sec = 6'd1;
    while (cyc < 23) begin
      step();
      bus_if.adj_min_n = (cyc == 17 || cyc == 19) ? 1'b0 : 1'b1;
    end
    check("rst_pre_inc", int'(bus_if.inc_min), 1);
    rst_n = 1'b0;
    #1;
    check("rst_async_inc", int'(bus_if.inc_min), 0);
    model_reset();
    repeat (3) step();
    rst_n = 1'b1;
    bus_if.rst_numb_sec = 6'd59;
    model_reset();
    n_rise = 0;
    run_to(40);
    check("rst_no_leftover", n_rise, 0);
`endif

    // Bouncy press followed by a long hold
    do_reset();
    while (cyc < 100) begin
      step();
      seg = cyc - 5;
      if (seg >= 0 && seg < 18)       bus_if.adj_min_n = ((seg / 3) % 2 == 0) ? 1'b0 : 1'b1;
      else if (seg >= 18 && seg < 38) bus_if.adj_min_n = 1'b0;
      else                            bus_if.adj_min_n = 1'b1;
    end
    check("bounce_rise", n_rise, DEB_BUILD ? 1 : 4);
    check("bounce_sec_unaffected", int'(bus_if.out_sec), 10);

    // Five one-cycle presses: pending saturates and one request is dropped
    do_reset();
    while (cyc < 80) begin
      step();
      bus_if.adj_min_n = (cyc >= 5 && cyc < 15 && (cyc % 2) == 1) ? 1'b0 : 1'b1;
    end
    check("cap_rise", n_rise, DEB_BUILD ? 0 : 4);

    // Randomised run against the reference model
    do_reset();
    bus_if.rst_numb_sec = 6'd5;
    repeat (1500) begin
      step();
      bus_if.run     = ($urandom_range(0, 7) != 0);
      bus_if.clr_sec = ($urandom_range(0, 79) == 0);
      if (!DEB_BUILD && $urandom_range(0, 5) == 0) bus_if.adj_min_n = ~bus_if.adj_min_n;
      if ($urandom_range(0, 299) == 0) bus_if.rst_numb_sec = 6'($urandom_range(0, 63));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
